// File: rtl/audio_decimator_if.sv
// audio_decimator_if: raw sample input and decimated signal output of the audio front-end
interface audio_decimator_if #(
  parameter int IN_WIDTH  = 12,
  parameter int SIG_WIDTH = 9
);
  logic [IN_WIDTH-1:0]  sample_in;
  logic                 sample_in_valid;
  logic [SIG_WIDTH-1:0] sig_out;
  logic                 sig_out_valid;
  logic                 clip_out;
  modport master (
    output sample_in, sample_in_valid,
    input  sig_out, sig_out_valid, clip_out
  );
  modport slave (
    input  sample_in, sample_in_valid,
    output sig_out, sig_out_valid, clip_out
  );
endinterface

// File: rtl/audio_decimator.sv
// audio_decimator: box-car decimate, DC-remove and saturate ADC samples for the pitch detector
module audio_decimator #(
  parameter int IN_WIDTH   = 12,
  parameter int SIG_WIDTH  = 9,
  parameter int DECIM_LOG2 = 2,
  parameter int DC_SHIFT   = 8
) (
  input logic               clk_in,
  input logic               rst_in,
  audio_decimator_if.slave  bus
);
  localparam int AW = IN_WIDTH + DECIM_LOG2;
  localparam int DW = IN_WIDTH + DC_SHIFT;
  localparam int CW = IN_WIDTH + 1;
  localparam logic [DW-1:0] DC_RST = DW'(1) << (IN_WIDTH - 1 + DC_SHIFT);
  localparam logic signed [CW-1:0] SMAX = CW'((1 << (SIG_WIDTH - 1)) - 1);
  localparam logic signed [CW-1:0] SMIN = ~SMAX;
  logic [AW-1:0] acc_q, acc_d, s1_q, s1_d, sum;
  logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dc_q, dc_d;
  logic [IN_WIDTH-1:0] avg, dc;
  logic signed [CW-1:0] c_q, c_d, scaled;
  logic [SIG_WIDTH-1:0] sig_q, sig_d;
  logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, valid_q, valid_d, clip_q, clip_d, last;
  // next state of accumulate, DC-removal and scale/saturate stages; the DC tracker uses its pre-update value
  always_comb begin
    sum = acc_q + AW'(bus.sample_in);
    last = bus.sample_in_valid && &cnt_q;
    cnt_d = bus.sample_in_valid ? cnt_q + 1'b1 : cnt_q;
    acc_d = last ? '0 : bus.sample_in_valid ? sum : acc_q;
    s1_d = last ? sum : s1_q;
    s1_valid_d = last;
    avg = s1_q[AW-1:DECIM_LOG2];
    dc = dc_q[DW-1:DC_SHIFT];
    c_d = s1_valid_q ? $signed({1'b0, avg}) - $signed({1'b0, dc}) : c_q;
    dc_d = s1_valid_q ? dc_q + DW'(avg) - DW'(dc) : dc_q;
    s2_valid_d = s1_valid_q;
    scaled = c_q >>> (IN_WIDTH - SIG_WIDTH);
    clip_d = s2_valid_q && (scaled > SMAX || scaled < SMIN);
    sig_d = !s2_valid_q ? sig_q : scaled > SMAX ? SMAX[SIG_WIDTH-1:0] :
            scaled < SMIN ? SMIN[SIG_WIDTH-1:0] : scaled[SIG_WIDTH-1:0];
    valid_d = s2_valid_q;
  end
  // pipeline registers; reset drops the partial block and anything in flight
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      acc_q <= '0;
      cnt_q <= '0;
      s1_q <= '0;
      s1_valid_q <= 1'b0;
      c_q <= '0;
      s2_valid_q <= 1'b0;
      dc_q <= DC_RST;
      sig_q <= '0;
      valid_q <= 1'b0;
      clip_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      s1_q <= s1_d;
      s1_valid_q <= s1_valid_d;
      c_q <= c_d;
      s2_valid_q <= s2_valid_d;
      dc_q <= dc_d;
      sig_q <= sig_d;
      valid_q <= valid_d;
      clip_q <= clip_d;
    end
  end
  assign bus.sig_out = sig_q;
  assign bus.sig_out_valid = valid_q;
  assign bus.clip_out = clip_q;
endmodule

// File: tb/tb_audio_decimator.sv
// tb_audio_decimator: directed vector bench for the audio decimator front-end
module tb_audio_decimator;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobes = 0;
  int last_strobe = -1;
  audio_decimator_if #(.IN_WIDTH(12), .SIG_WIDTH(9)) bus ();
  audio_decimator #(.IN_WIDTH(12), .SIG_WIDTH(9), .DECIM_LOG2(2), .DC_SHIFT(8)) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.sig_out_valid === 1'b1) begin
    strobes <= strobes + 1;
    last_strobe <= cyc;
  end
  typedef struct {
    string name;
    bit rst;
    logic [3:0][11:0] v;
    int sig;
    int clip;
  } vec_t;
  vec_t tv[$];
  task automatic add(input string n, input bit r, input logic [11:0] a, b, c, d, input int s, input int cl);
    vec_t x;
    x.name = n;
    x.rst = r;
    x.v = {a, b, c, d};
    x.sig = s;
    x.clip = cl;
    tv.push_back(x);
  endtask
  task automatic check(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.sample_in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_sig", int'($signed(bus.sig_out)), 0);
    check("rst_valid", int'(bus.sig_out_valid), 0);
    check("rst_clip", int'(bus.clip_out), 0);
  endtask
  task automatic do_block(input string n, input logic [3:0][11:0] v, input int es, input int ec);
    for (int i = 3; i >= 0; i--) begin
      @(posedge clk); #1;
      bus.sample_in_valid = 1'b1;
      bus.sample_in = v[i];
    end
    @(posedge clk); #1;
    bus.sample_in_valid = 1'b0;
    check({n, "_early1"}, int'(bus.sig_out_valid), 0);
    @(posedge clk); #1;
    check({n, "_early2"}, int'(bus.sig_out_valid), 0);
    @(posedge clk); #1;
    check({n, "_valid"}, int'(bus.sig_out_valid), 1);
    check({n, "_sig"}, int'($signed(bus.sig_out)), es);
    check({n, "_clip"}, int'(bus.clip_out), ec);
    @(posedge clk); #1;
    check({n, "_after_valid"}, int'(bus.sig_out_valid), 0);
    check({n, "_after_clip"}, int'(bus.clip_out), 0);
    check({n, "_hold"}, int'($signed(bus.sig_out)), es);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    int base;
    int t;
    bus.sample_in = '0;
    bus.sample_in_valid = 1'b0;
    add("mid0",  1, 2048, 2048, 2048, 2048, 0, 0);
    add("mid1",  0, 2048, 2048, 2048, 2048, 0, 0);
    add("up0",   1, 2560, 2560, 2560, 2560, 64, 0);
    add("up1",   0, 2560, 2560, 2560, 2560, 63, 0);
    add("neg0",  1, 2040, 2040, 2040, 2040, -1, 0);
    add("neg1",  0, 2041, 2041, 2041, 2041, -1, 0);
    add("pos1",  0, 2056, 2056, 2056, 2063, 1, 0);
    add("zero0", 1, 0, 0, 0, 0, -256, 0);
    add("zero1", 0, 0, 0, 0, 0, -255, 0);
    add("full",  1, 4095, 4095, 4095, 4095, 255, 0);
    add("trunc", 1, 0, 1, 2, 3, -256, 0);
    add("tiny",  1, 2051, 2050, 2049, 2048, 0, 0);
    add("m1",    1, 2047, 2047, 2047, 2047, -1, 0);
    foreach (tv[i]) begin
      if (tv[i].rst) do_reset();
      do_block(tv[i].name, tv[i].v, tv[i].sig, tv[i].clip);
    end
    do_reset();
    base = strobes;
    t = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      bus.sample_in_valid = 1'b1;
      bus.sample_in = 12'd2560;
      t = cyc;
      @(posedge clk); #1;
      bus.sample_in_valid = 1'b0;
      @(posedge clk); #1;
      check("gap_hold", int'($signed(bus.sig_out)), 0);
    end
    check("gap_nostrobe", strobes - base, 0);
    @(posedge clk); #1;
    check("gap_valid", int'(bus.sig_out_valid), 1);
    check("gap_sig", int'($signed(bus.sig_out)), 64);
    repeat (4) @(posedge clk);
    #1;
    check("gap_count", strobes - base, 1);
    check("gap_latency", last_strobe, t + 3);
    check("gap_held", int'($signed(bus.sig_out)), 64);
    do_reset();
    base = strobes;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      bus.sample_in_valid = 1'b1;
      bus.sample_in = 12'd4095;
    end
    @(posedge clk); #1;
    bus.sample_in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    do_block("discard", {4{12'd2560}}, 64, 0);
    repeat (6) @(posedge clk);
    #1;
    check("discard_count", strobes - base, 1);
    do_reset();
    repeat (4 * 4096) begin
      @(posedge clk); #1;
      bus.sample_in_valid = 1'b1;
      bus.sample_in = 12'd4095;
    end
    do_block("sat", {4{12'd0}}, -256, 1);
    do_block("unsat", {4{12'd4095}}, 2, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
